// File: rtl/grid_io_bank_if.sv
// Configuration and fabric-side signal bundle for grid_io_bank.
interface grid_io_bank_if #(
    parameter int unsigned NUM_IO = 8
) ();
    localparam int unsigned CHAIN_LEN = 3 * NUM_IO;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 2);

    logic                  cfg_done;
    logic                  ccff_head;
    logic                  ccff_tail;
    logic [0:NUM_IO-1]     io_outpad;
    logic [0:NUM_IO-1]     io_inpad;
    logic                  cfg_locked;
    logic                  cfg_err;
    logic [CNT_W-1:0]      cfg_bit_count;

    // Driver side: configuration controller and fabric routing.
    modport master (
        output cfg_done, ccff_head, io_outpad,
        input  ccff_tail, io_inpad, cfg_locked, cfg_err, cfg_bit_count
    );

    // The I/O bank itself.
    modport slave (
        input  cfg_done, ccff_head, io_outpad,
        output ccff_tail, io_inpad, cfg_locked, cfg_err, cfg_bit_count
    );
endinterface

// File: rtl/grid_io_bank.sv
// Perimeter GPIO tile: NUM_IO pads behind one config shift chain with
// length checking and pad gating until the configuration is validated.
module grid_io_bank #(
    parameter int unsigned NUM_IO = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    inout  wire  [0:NUM_IO-1] gfpga_pad_GPIO_PAD,
    grid_io_bank_if.slave     bus
);
    localparam int unsigned CHAIN_LEN = 3 * NUM_IO;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 2);

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic [CHAIN_LEN-1:0] act_q, act_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [0:NUM_IO-1]    inpad_c;

    // State, shift chain, active config and flags; reset aborts everything.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            state_q  <= ST_SHIFT;
            sr_q     <= '0;
            act_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            act_q    <= act_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    // Next-state: shift while cfg_done is low, validate length when it rises.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        err_d    = err_q;
        case (state_q)
            ST_SHIFT: begin
                if (!bus.cfg_done) begin
                    sr_d = {sr_q[CHAIN_LEN-2:0], bus.ccff_head};
                    if (cnt_q != CNT_W'(CHAIN_LEN + 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q == CNT_W'(CHAIN_LEN)) begin
                    act_d    = sr_q;
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                end else begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_LOCKED: begin
                // SR is kept so the config can be read back by shifting.
                if (!bus.cfg_done) begin
                    state_d  = ST_SHIFT;
                    act_d    = '0;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                end
            end
            ST_ERROR: begin
                if (!bus.cfg_done) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_SHIFT;
                act_d    = '0;
                cnt_d    = '0;
                locked_d = 1'b0;
                err_d    = 1'b0;
            end
        endcase
    end

    // Pad drivers: tri-stated unless locked with output enable set.
    for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
        assign gfpga_pad_GPIO_PAD[i] = (state_q == ST_LOCKED && act_q[3*i])
                                     ? (bus.io_outpad[i] ^ act_q[3*i+1]) : 1'bz;
    end

    // Pad readback into the fabric, forced to 0 until locked.
    always_comb begin
        inpad_c = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (state_q == ST_LOCKED) begin
                inpad_c[i] = gfpga_pad_GPIO_PAD[i] ^ act_q[3*i+2];
            end
        end
    end

    assign bus.io_inpad      = inpad_c;
    assign bus.ccff_tail     = sr_q[CHAIN_LEN-1];
    assign bus.cfg_locked    = locked_q;
    assign bus.cfg_err       = err_q;
    assign bus.cfg_bit_count = cnt_q;
endmodule
